cache_bank_be: RTL and testbench

Parametrised successor data bank for I/D caches: one write port, one read port, per-byte write enables and registered reads.
Same-cycle read/write collisions are resolved by byte-merged forwarding.
A built-in clear engine fills every entry with INIT_VALUE after reset or on request, so cache flush no longer needs a controller-driven sweep.
Sits under the cache controller in place of the word-only bank.

---
 rtl/cache_bank_pkg.sv | 15 +
 rtl/cache_bank_be_core.sv | 36 +++
 rtl/cache_bank_be.sv | 145 ++++++++++++++
 tb/tb_cache_bank_be.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/cache_bank_pkg.sv
// Shared types and helpers for the byte-enable cache data bank.
package cache_bank_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clear_state_t;

  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       be);
    return be ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/cache_bank_be_core.sv
// Plain byte-enable RAM: one write port, one registered read port returning pre-write data.
import cache_bank_pkg::*;

module cache_bank_be_core #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDR_WIDTH-1:0]   waddr_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic                    re_i,
  input  logic [ADDR_WIDTH-1:0]   raddr_i,
  output logic [DATA_WIDTH-1:0]   rdata_o
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Non-blocking update means a same-edge read sees the old contents.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int k = 0; k < BYTES; k++) begin
        if (be_i[k]) mem_q[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_bank_be.sv
// Cache data bank with byte enables, collision forwarding and a built-in clear sweep.
import cache_bank_pkg::*;

module cache_bank_be #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDR_WIDTH    = 7,
  parameter bit                    INIT_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_clear,
  output logic                    o_busy,
  input  logic                    i_we,
  input  logic [DATA_WIDTH/8-1:0] i_wbe,
  input  logic [ADDR_WIDTH-1:0]   i_waddr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic                    i_re,
  input  logic [ADDR_WIDTH-1:0]   i_raddr,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_rvalid
);

  localparam int                  BYTES    = DATA_WIDTH / 8;
  localparam int                  DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

  clear_state_t          state_q;
  logic                  busy_q;
  logic [ADDR_WIDTH:0]   cnt_q;

  logic                  idle;
  logic                  readAcc;
  logic                  writeAcc;

  logic                  ramWe;
  logic [BYTES-1:0]      ramBe;
  logic [ADDR_WIDTH-1:0] ramWaddr;
  logic [DATA_WIDTH-1:0] ramWdata;
  logic [DATA_WIDTH-1:0] coreRdata;

  logic                  rvalid_q;
  logic                  haveData_q;
  logic                  fwdHit_q;
  logic [BYTES-1:0]      fwdBe_q;
  logic [DATA_WIDTH-1:0] fwdData_q;
  logic [DATA_WIDTH-1:0] mergedData;

  assign idle     = (state_q == IDLE);
  assign readAcc  = idle & i_re;
  assign writeAcc = idle & i_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT_ON_RESET ? CLEAR : IDLE;
      busy_q  <= INIT_ON_RESET;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_clear) begin
            state_q <= CLEAR;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST_IDX) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // The sweep owns the write port outright; user traffic is dropped while busy.
  always_comb begin
    ramWe    = writeAcc;
    ramBe    = i_wbe;
    ramWaddr = i_waddr;
    ramWdata = i_wdata;
    if (!idle) begin
      ramWe    = 1'b1;
      ramBe    = '1;
      ramWaddr = cnt_q[ADDR_WIDTH-1:0];
      ramWdata = INIT_VALUE;
    end
  end

  cache_bank_be_core #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_core (
    .clk    (clk),
    .we_i   (ramWe),
    .be_i   (ramBe),
    .waddr_i(ramWaddr),
    .wdata_i(ramWdata),
    .re_i   (readAcc),
    .raddr_i(i_raddr),
    .rdata_o(coreRdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q   <= 1'b0;
      haveData_q <= 1'b0;
      fwdHit_q   <= 1'b0;
      fwdBe_q    <= '0;
      fwdData_q  <= '0;
    end else begin
      rvalid_q <= readAcc;
      if (readAcc) begin
        haveData_q <= 1'b1;
        fwdHit_q   <= writeAcc && (i_waddr == i_raddr);
        fwdBe_q    <= i_wbe;
        fwdData_q  <= i_wdata;
      end
    end
  end

  // Forwarding state only changes with a read, so the merged word holds between reads.
  always_comb begin
    mergedData = coreRdata;
    if (fwdHit_q) begin
      for (int k = 0; k < BYTES; k++) begin
        mergedData[8*k +: 8] = byte_merge(coreRdata[8*k +: 8], fwdData_q[8*k +: 8], fwdBe_q[k]);
      end
    end
  end

  assign o_rdata  = haveData_q ? mergedData : '0;
  assign o_rvalid = rvalid_q;
  assign o_busy   = busy_q;

endmodule

// File: tb/tb_cache_bank_be.sv
// Self-checking bench for cache_bank_be: directed vector table plus multi-cycle corner sequences.
module tb_cache_bank_be;

  localparam int          DW    = 32;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] INITV = 32'hC0DE_0001;

  logic          clk;
  logic          rst_n;
  logic          i_clear;
  logic          o_busy;
  logic          i_we;
  logic [3:0]    i_wbe;
  logic [AW-1:0] i_waddr;
  logic [DW-1:0] i_wdata;
  logic          i_re;
  logic [AW-1:0] i_raddr;
  logic [DW-1:0] o_rdata;
  logic          o_rvalid;

  int nCompared   = 0;
  int nMismatched = 0;

  cache_bank_be #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .INIT_ON_RESET(1'b1),
    .INIT_VALUE   (INITV)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (i_clear),
    .o_busy  (o_busy),
    .i_we    (i_we),
    .i_wbe   (i_wbe),
    .i_waddr (i_waddr),
    .i_wdata (i_wdata),
    .i_re    (i_re),
    .i_raddr (i_raddr),
    .o_rdata (o_rdata),
    .o_rvalid(o_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [3:0]    wbe;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          re;
    logic [AW-1:0] raddr;
    logic          expValid;
    logic [31:0]   expData;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [3:0] wbe, input logic [AW-1:0] waddr,
                              input logic [31:0] wdata, input logic re, input logic [AW-1:0] raddr,
                              input logic expValid, input logic [31:0] expData);
    vec_t v;
    v.we = we; v.wbe = wbe; v.waddr = waddr; v.wdata = wdata;
    v.re = re; v.raddr = raddr; v.expValid = expValid; v.expData = expData;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic setIdle();
    i_clear = 1'b0; i_we = 1'b0; i_wbe = 4'h0; i_waddr = '0;
    i_wdata = '0; i_re = 1'b0; i_raddr = '0;
  endtask

  // Drive one cycle's inputs, then sample 1ns after the edge that consumes them.
  task automatic applyStimulus(input logic we, input logic [3:0] wbe, input logic [AW-1:0] waddr,
                               input logic [31:0] wdata, input logic re, input logic [AW-1:0] raddr,
                               input logic clr);
    i_we = we; i_wbe = wbe; i_waddr = waddr; i_wdata = wdata;
    i_re = re; i_raddr = raddr; i_clear = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk);
      #1;
      n++;
      if (!o_busy) return;
    end
  endtask

  task automatic readExpect(input string name, input logic [AW-1:0] addr, input logic [31:0] exp);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b1, addr, 1'b0);
    checkOutput({name, "_rvalid"}, 32'(o_rvalid), 32'd1);
    checkOutput({name, "_rdata"}, o_rdata, exp);
  endtask

  int n;
  logic [31:0] holdVal;

  initial begin
    setIdle();
    rst_n = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(o_busy), 32'd1);
    checkOutput("rst_rdata", o_rdata, 32'h0);
    checkOutput("rst_rvalid", 32'(o_rvalid), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    waitIdle(n);
    checkOutput("init_sweep_cycles", 32'(n), 32'd16);

    for (int i = 0; i < DEPTH; i++) begin
      vecs.push_back(mk(1'b0, 4'h0, '0, '0, 1'b1, AW'(i), 1'b1, INITV));
    end
    vecs.push_back(mk(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0, 1'b0, INITV));
    vecs.push_back(mk(1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0, 1'b0, INITV));
    vecs.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd3, 1'b1, 32'hAA22CC44));
    vecs.push_back(mk(1'b1, 4'hF, 4'd5, 32'hDEADBEEF, 1'b0, 4'd0, 1'b0, 32'hAA22CC44));
    vecs.push_back(mk(1'b1, 4'h3, 4'd5, 32'h00000000, 1'b1, 4'd5, 1'b1, 32'hDEAD0000));
    vecs.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 1'b1, 32'hDEAD0000));
    vecs.push_back(mk(1'b1, 4'h0, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5, 1'b1, 32'hDEAD0000));
    vecs.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd5, 1'b1, 32'hDEAD0000));
    vecs.push_back(mk(1'b1, 4'hF, 4'd6, 32'h12345678, 1'b1, 4'd6, 1'b1, 32'h12345678));
    vecs.push_back(mk(1'b1, 4'h8, 4'd6, 32'hAB000000, 1'b1, 4'd6, 1'b1, 32'hAB345678));
    vecs.push_back(mk(1'b1, 4'hF, 4'd7, 32'h77777777, 1'b1, 4'd6, 1'b1, 32'hAB345678));
    vecs.push_back(mk(1'b0, 4'h0, 4'd0, 32'h0,        1'b1, 4'd7, 1'b1, 32'h77777777));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].wbe, vecs[i].waddr, vecs[i].wdata,
                    vecs[i].re, vecs[i].raddr, 1'b0);
      checkOutput($sformatf("vec%0d_rvalid", i), 32'(o_rvalid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_rdata", i), o_rdata, vecs[i].expData);
    end

    // rvalid pulses once; a later write to the same entry leaves the registered word alone.
    readExpect("pulse_rd", 4'd3, 32'hAA22CC44);
    applyStimulus(1'b1, 4'hF, 4'd3, 32'h0BADF00D, 1'b0, 4'd0, 1'b0);
    checkOutput("pulse_rvalid_drop", 32'(o_rvalid), 32'd0);
    checkOutput("pulse_rdata_hold", o_rdata, 32'hAA22CC44);
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 4'd0, 1'b0);
    checkOutput("pulse_rdata_hold2", o_rdata, 32'hAA22CC44);
    readExpect("pulse_rd_new", 4'd3, 32'h0BADF00D);

    // Clear sweep with junk traffic that must all be dropped.
    readExpect("pre_clr_rd", 4'd6, 32'hAB345678);
    holdVal = 32'hAB345678;
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 4'd0, 1'b1);
    checkOutput("clr_busy_start", 32'(o_busy), 32'd1);
    n = 1;
    for (int c = 0; c < 100; c++) begin
      applyStimulus(1'b1, 4'hF, AW'(c) - 4'd1, 32'hFFFFFFFF, 1'b1, AW'(c), 1'b1);
      if (!o_busy) break;
      n++;
      checkOutput("clr_rvalid", 32'(o_rvalid), 32'd0);
      checkOutput("clr_rdata_hold", o_rdata, holdVal);
    end
    setIdle();
    checkOutput("clr_sweep_cycles", 32'(n), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      readExpect($sformatf("post_clr%0d", i), AW'(i), INITV);
    end

    // Reset mid-sweep aborts and restarts the sweep from entry 0.
    applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 4'd0, 1'b1);
    repeat (7) applyStimulus(1'b0, 4'h0, '0, '0, 1'b0, 4'd0, 1'b0);
    checkOutput("midrst_pre_busy", 32'(o_busy), 32'd1);
    checkOutput("midrst_pre_rdata", o_rdata, INITV);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 32'(o_busy), 32'd1);
    checkOutput("midrst_rdata", o_rdata, 32'h0);
    checkOutput("midrst_rvalid", 32'(o_rvalid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    waitIdle(n);
    checkOutput("midrst_sweep_cycles", 32'(n), 32'd16);
    readExpect("midrst_rd0", 4'd0, INITV);
    readExpect("midrst_rd15", 4'd15, INITV);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
